// File: rtl/axi_udp_pkg.sv
// Shared constants, state encoding and small helpers for the Ethernet receive path.
package axi_udp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_HDR_LEN    = 14;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_ARP  = 2'd1,
    ST_IP   = 2'd2,
    ST_DROP = 2'd3
  } eth_rx_state_t;

  // Byte idx of a MAC address, byte 0 being the first on the wire (MSB).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = mac[47:40];
      4'd1:    b = mac[39:32];
      4'd2:    b = mac[31:24];
      4'd3:    b = mac[23:16];
      4'd4:    b = mac[15:8];
      4'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_eth_rx_if.sv
// Byte-wide AXI-Stream bundle used for the frame input and both payload outputs.
interface axi_eth_rx_if;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tlast;
  logic       tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_reg_slice.sv
// One-entry AXI-Stream register stage (data + last): 1-cycle latency, full throughput.
module axi_reg_slice (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  input  logic       i_ready
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_last;
  logic       w_ready;

  // The stage can take a new byte when empty or when its current byte leaves this cycle.
  assign w_ready = ~r_valid | i_ready;

  // Load on an upstream handshake, otherwise empty out once the byte is taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_last  <= 1'b0;
    end else if (i_valid && w_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/axi_eth_rx.sv
// Ethernet RX demux: strips the 14-byte MAC header, filters on destination MAC and
// steers the payload by EtherType to the ARP or IPv4 stream; other frames are counted.
module axi_eth_rx
  import axi_udp_pkg::*;
#(
  parameter logic [23:0] MAC_MSB = 24'h010203,
  parameter logic [23:0] MAC_LSB = 24'h040506
) (
  input  logic          clk,
  input  logic          rst,
  axi_eth_rx_if.slave   s_axis,
  axi_eth_rx_if.master  m_arp_axis,
  axi_eth_rx_if.master  m_ip_axis,
  output logic [47:0]   src_mac,
  output logic [15:0]   drop_cnt
);

  localparam logic [47:0] OWN_MAC  = {MAC_MSB, MAC_LSB};
  localparam logic [3:0]  IDX_LAST = 4'(ETH_HDR_LEN - 1);

  eth_rx_state_t r_state;
  logic [3:0]    r_idx;
  logic          r_own;
  logic          r_bcast;
  logic [7:0]    r_etype_hi;
  logic [47:0]   r_src_mac;
  logic [15:0]   r_drop_cnt;

  logic          w_tready;
  logic          w_accept;
  logic          w_arp_rdy;
  logic          w_ip_rdy;
  logic          w_own_hit;
  logic          w_bcast_hit;
  logic [15:0]   w_etype;
  eth_rx_state_t w_decide;

  // Header/drop states always sink; payload states follow the selected output stage.
  always_comb begin
    w_tready = 1'b0;
    if (rst) begin
      w_tready = 1'b0;
    end else begin
      case (r_state)
        ST_HDR:  w_tready = 1'b1;
        ST_DROP: w_tready = 1'b1;
        ST_ARP:  w_tready = w_arp_rdy;
        ST_IP:   w_tready = w_ip_rdy;
        default: w_tready = 1'b0;
      endcase
    end
  end

  assign s_axis.tready = w_tready;
  assign w_accept      = s_axis.tvalid & w_tready;

  // Match flags restart at byte 0 so a new frame never inherits the previous result.
  assign w_own_hit   = (s_axis.tdata == mac_byte(OWN_MAC, r_idx))   & ((r_idx == 4'd0) | r_own);
  assign w_bcast_hit = (s_axis.tdata == mac_byte(MAC_BCAST, r_idx)) & ((r_idx == 4'd0) | r_bcast);
  assign w_etype     = {r_etype_hi, s_axis.tdata};

  // Payload destination chosen on the last header byte.
  always_comb begin
    w_decide = ST_DROP;
    if ((w_etype == ETHERTYPE_ARP) && (r_own || r_bcast)) begin
      w_decide = ST_ARP;
    end else if ((w_etype == ETHERTYPE_IPV4) && r_own) begin
      w_decide = ST_IP;
    end else begin
      w_decide = ST_DROP;
    end
  end

  // Header parser, frame router and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HDR;
      r_idx      <= 4'd0;
      r_own      <= 1'b0;
      r_bcast    <= 1'b0;
      r_etype_hi <= 8'h00;
      r_src_mac  <= 48'h0;
      r_drop_cnt <= 16'h0000;
    end else if (w_accept) begin
      case (r_state)
        ST_HDR: begin
          if (r_idx <= 4'd5) begin
            r_own   <= w_own_hit;
            r_bcast <= w_bcast_hit;
          end else if (r_idx <= 4'd11) begin
            r_src_mac <= {r_src_mac[39:0], s_axis.tdata};
          end else if (r_idx == 4'd12) begin
            r_etype_hi <= s_axis.tdata;
          end
          if (s_axis.tlast) begin
            // Runt: frame ended inside the header, nothing was forwarded.
            r_idx      <= 4'd0;
            r_drop_cnt <= sat_inc16(r_drop_cnt);
          end else if (r_idx == IDX_LAST) begin
            r_idx   <= 4'd0;
            r_state <= w_decide;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_ARP, ST_IP: begin
          if (s_axis.tlast) begin
            r_state <= ST_HDR;
          end
        end
        ST_DROP: begin
          if (s_axis.tlast) begin
            r_state    <= ST_HDR;
            r_drop_cnt <= sat_inc16(r_drop_cnt);
          end
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

  axi_reg_slice u_arp_slice (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept & (r_state == ST_ARP)),
    .i_data  (s_axis.tdata),
    .i_last  (s_axis.tlast),
    .o_ready (w_arp_rdy),
    .o_valid (m_arp_axis.tvalid),
    .o_data  (m_arp_axis.tdata),
    .o_last  (m_arp_axis.tlast),
    .i_ready (m_arp_axis.tready)
  );

  axi_reg_slice u_ip_slice (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept & (r_state == ST_IP)),
    .i_data  (s_axis.tdata),
    .i_last  (s_axis.tlast),
    .o_ready (w_ip_rdy),
    .o_valid (m_ip_axis.tvalid),
    .o_data  (m_ip_axis.tdata),
    .o_last  (m_ip_axis.tlast),
    .i_ready (m_ip_axis.tready)
  );

  assign src_mac  = r_src_mac;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_axi_eth_rx.sv
// Directed bench for axi_eth_rx: builds frames, scoreboards both payload streams.
module tb_axi_eth_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] src_mac;
  logic [15:0] drop_cnt;

  axi_eth_rx_if s_axis ();
  axi_eth_rx_if m_arp ();
  axi_eth_rx_if m_ip ();

  axi_eth_rx #(.MAC_MSB(24'h010203), .MAC_LSB(24'h040506)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s_axis),
    .m_arp_axis (m_arp),
    .m_ip_axis  (m_ip),
    .src_mac    (src_mac),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [8:0] arp_q[$];
  logic [8:0] ip_q[$];
  int         ip_cyc_q[$];
  int         in_cyc_q[$];
  bit         bp_mode      = 1'b0;
  bit         in_pay       = 1'b0;
  bit         rdy_low_seen = 1'b0;
  bit         prev_stall   = 1'b0;
  logic [8:0] prev_word    = 9'h000;

  localparam logic [47:0] OWN   = 48'h010203040506;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  // Cycle counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: samples just after the falling edge, for the coming rising edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (prev_stall) begin
        check_value("arp_hold_valid", 64'(m_arp.tvalid), 64'd1);
        check_value("arp_hold_data", 64'({m_arp.tlast, m_arp.tdata}), 64'(prev_word));
      end
      if (m_arp.tvalid && m_arp.tready) arp_q.push_back({m_arp.tlast, m_arp.tdata});
      if (m_ip.tvalid && m_ip.tready) begin
        ip_q.push_back({m_ip.tlast, m_ip.tdata});
        ip_cyc_q.push_back(cyc + 1);
      end
      if (in_pay && m_arp.tvalid && !m_arp.tready)
        check_value("bp_s_tready", 64'(s_axis.tready), 64'd0);
      prev_stall = m_arp.tvalid && !m_arp.tready;
      prev_word  = {m_arp.tlast, m_arp.tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                       input int plen, input logic [31:0] hdr4, input logic [7:0] seed);
    logic [7:0] b;
    tx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) tx_q.push_back(src[47-8*i -: 8]);
    tx_q.push_back(et[15:8]);
    tx_q.push_back(et[7:0]);
    for (int j = 0; j < plen; j++) begin
      if (j < 4) b = hdr4[31-8*j -: 8];
      else b = seed + 8'(j * 13);
      tx_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_q(input bit with_last);
    int tmo;
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = tx_q[i];
      s_axis.tlast  = with_last && (i == tx_q.size() - 1);
      in_pay        = (i >= 14);
      if (bp_mode) m_arp.tready = 1'($urandom_range(0, 1));
      #1;
      tmo = 0;
      while (!s_axis.tready && tmo < 200) begin
        rdy_low_seen = 1'b1;
        @(negedge clk);
        if (bp_mode) m_arp.tready = 1'($urandom_range(0, 1));
        #1;
        tmo++;
      end
      if (tmo >= 200) check_value("send_timeout", 64'(tmo), 64'd0);
      if (i >= 14) in_cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    in_pay        = 1'b0;
    m_arp.tready  = 1'b1;
  endtask

  task automatic clear_q();
    arp_q.delete();
    ip_q.delete();
    ip_cyc_q.delete();
    in_cyc_q.delete();
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst           = 1'b1;
    s_axis.tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic cmp_stream(input string tag, input bit is_ip, input int exp_len);
    logic [8:0] got[$];
    logic       lastb;
    if (is_ip) got = ip_q;
    else got = arp_q;
    check_value({tag, "_len"}, 64'(got.size()), 64'(exp_len));
    for (int k = 0; k < exp_len && k < got.size(); k++) begin
      lastb = (k == exp_len - 1);
      check_value($sformatf("%s_b%0d", tag, k), 64'(got[k]), 64'({lastb, exp_q[k]}));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tlast  = 1'b0;
    m_arp.tready  = 1'b1;
    m_ip.tready   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    check_value("rst_s_tready", 64'(s_axis.tready), 64'd0);
    check_value("rst_arp_valid", 64'(m_arp.tvalid), 64'd0);
    check_value("rst_arp_data", 64'({m_arp.tlast, m_arp.tdata}), 64'd0);
    check_value("rst_ip_valid", 64'(m_ip.tvalid), 64'd0);
    check_value("rst_src_mac", 64'(src_mac), 64'd0);
    check_value("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("post_rst_s_tready", 64'(s_axis.tready), 64'd1);
    clear_q();

    // Broadcast ARP
    build(BCAST, 48'h0a0b0c0d0e0f, 16'h0806, 28, 32'h00010800, 8'h11);
    send_q(1'b1);
    drain();
    cmp_stream("arp_bc", 1'b0, 28);
    check_value("arp_bc_ip_none", 64'(ip_q.size()), 64'd0);
    check_value("arp_bc_src_mac", 64'(src_mac), 64'h0a0b0c0d0e0f);
    check_value("arp_bc_drop", 64'(drop_cnt), 64'd0);

    // IPv4 to own MAC, then the same frame to broadcast
    reset_dut();
    build(OWN, 48'h0a1b2c3d4e5f, 16'h0800, 20, 32'h45000014, 8'h22);
    send_q(1'b1);
    drain();
    cmp_stream("ip_own", 1'b1, 20);
    check_value("ip_own_arp_none", 64'(arp_q.size()), 64'd0);
    if (ip_cyc_q.size() >= 20 && in_cyc_q.size() >= 20) begin
      check_value("ip_lat_first", 64'(ip_cyc_q[0] - in_cyc_q[0]), 64'd1);
      check_value("ip_lat_last", 64'(ip_cyc_q[19] - in_cyc_q[19]), 64'd1);
    end
    check_value("ip_own_drop", 64'(drop_cnt), 64'd0);
    clear_q();
    build(BCAST, 48'h0a1b2c3d4e5f, 16'h0800, 20, 32'h45000014, 8'h22);
    send_q(1'b1);
    drain();
    check_value("ip_bc_none", 64'(ip_q.size()), 64'd0);
    check_value("ip_bc_drop", 64'(drop_cnt), 64'd1);

    // Filtering: foreign MAC ARP, own MAC with unknown EtherType
    reset_dut();
    rdy_low_seen = 1'b0;
    build(48'h010203040507, 48'h0a0b0c0d0e0f, 16'h0806, 28, 32'h00010800, 8'h33);
    send_q(1'b1);
    build(OWN, 48'h0a0b0c0d0e0f, 16'h86dd, 20, 32'h60000000, 8'h44);
    send_q(1'b1);
    drain();
    check_value("flt_arp_none", 64'(arp_q.size()), 64'd0);
    check_value("flt_ip_none", 64'(ip_q.size()), 64'd0);
    check_value("flt_drop", 64'(drop_cnt), 64'd2);
    check_value("flt_tready_high", 64'(rdy_low_seen), 64'd0);

    // Runts: 10 bytes, then exactly 14 bytes (last on header byte 13), then a good ARP
    reset_dut();
    build(OWN, 48'h112233445566, 16'h0806, 0, 32'h0, 8'h00);
    while (tx_q.size() > 10) void'(tx_q.pop_back());
    send_q(1'b1);
    drain();
    check_value("runt10_drop", 64'(drop_cnt), 64'd1);
    build(OWN, 48'h778899aabbcc, 16'h0806, 0, 32'h0, 8'h00);
    send_q(1'b1);
    drain();
    check_value("runt14_drop", 64'(drop_cnt), 64'd2);
    check_value("runt14_src_mac", 64'(src_mac), 64'h778899aabbcc);
    check_value("runt_arp_none", 64'(arp_q.size()), 64'd0);
    build(BCAST, 48'h0a0b0c0d0e0f, 16'h0806, 28, 32'h00010800, 8'h55);
    send_q(1'b1);
    drain();
    cmp_stream("runt_next", 1'b0, 28);
    check_value("runt_next_drop", 64'(drop_cnt), 64'd2);

    // Backpressure on the ARP output
    reset_dut();
    bp_mode = 1'b1;
    build(BCAST, 48'h0a0b0c0d0e0f, 16'h0806, 28, 32'h00010800, 8'h66);
    send_q(1'b1);
    bp_mode = 1'b0;
    drain();
    cmp_stream("bp", 1'b0, 28);

    // Reset in the middle of an ARP payload (while payload byte 5 sits in the output stage)
    reset_dut();
    build(OWN, 48'h112233445566, 16'h0806, 0, 32'h0, 8'h00);
    while (tx_q.size() > 10) void'(tx_q.pop_back());
    send_q(1'b1);
    drain();
    check_value("mid_pre_drop", 64'(drop_cnt), 64'd1);
    clear_q();
    build(BCAST, 48'h0a0b0c0d0e0f, 16'h0806, 28, 32'h00010800, 8'h77);
    while (tx_q.size() > 19) void'(tx_q.pop_back());
    send_q(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("mid_arp_valid", 64'(m_arp.tvalid), 64'd0);
    check_value("mid_drop", 64'(drop_cnt), 64'd0);
    check_value("mid_pre_len", 64'(arp_q.size()), 64'd4);
    clear_q();
    build(BCAST, 48'h0a0b0c0d0e0f, 16'h0806, 28, 32'h00010800, 8'h88);
    send_q(1'b1);
    drain();
    cmp_stream("mid_fresh", 1'b0, 28);
    check_value("mid_fresh_drop", 64'(drop_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
